edge_event_arbiter: RTL
=======================

// Module: edge_event_arbiter
// PURPOSE
//  Collects rising/falling-edge pulses from NUM_CH edgeDetector instances
//  (one per pushbutton/switch) into pending flags. Serializes the flags to a
//  single consumer through a valid/ready handshake, using round-robin order.
//  Sits between the per-input edge detectors and the board control FSM, so
//  that no edge pulse is lost while the consumer is busy.
// PARAMETERS
//  NUM_CH  5  number of edge-detector channels (Nexys4 DDR: 5 buttons)
//  IDX_W   3  width of channel index; must satisfy 2**IDX_W >= NUM_CH
// PORTS
//  clk          in   1       system clock; all logic on rising edge
//  resetN       in   1       asynchronous, active-low reset
//  riseIn       in   NUM_CH  risingEdge pulses, one clk wide, one bit per channel
//  fallIn       in   NUM_CH  fallingEdge pulses, one clk wide, one bit per channel
//  enableMask   in   NUM_CH  1 = channel may post new events
//  evtReady     in   1       consumer accepts the offered event
//  evtValid     out  1       event offered on evtChan/evtRising
//  evtChan      out  IDX_W   channel index of the offered event
//  evtRising    out  1       1 = rising edge, 0 = falling edge
//  pending      out  NUM_CH  OR of the rise and fall pending flags, per channel
//  overflow     out  1       sticky: an edge arrived while its flag was already set
//  overflowClr  in   1       one-cycle pulse; clears overflow
// BEHAVIOUR
//  Reset (resetN=0, async): all pending flags, evtValid, evtChan, evtRising
//   and overflow go to 0. FSM goes to IDLE. RR pointer = last slot, so the
//   first search after reset starts at slot 0.
//  Slots: 2*NUM_CH flags. Slot 2c = rise of channel c, slot 2c+1 = fall of c.
//  Set: at a clk edge where riseIn[c]&enableMask[c] (or fallIn) is 1, the slot
//   flag is set. Rise and fall in the same cycle set both slots.
//  Mask: gates new sets only. Clearing a mask bit does not clear existing
//   flags or withdraw an event already on offer.
//  Overflow: a set arrives for a flag that is already 1 and is not being
//   cleared by a grant in the same cycle. Result: overflow <= 1 and the
//   extra event is dropped. If set and overflowClr occur in the same cycle,
//   set wins.
//  Set+grant same cycle on the same slot: the flag stays 1 (the new event is
//   kept). overflow is not asserted.
//  FSM:
//   IDLE:  if any flag is set, pick the first set slot after the RR pointer,
//          with wrap-around. Register its chan/edge into evtChan/evtRising,
//          set evtValid=1 and go to OFFER. Otherwise stay in IDLE with
//          evtValid=0.
//   OFFER: evtValid, evtChan and evtRising are held stable while
//          evtReady=0. On evtReady=1: clear the granted flag, RR pointer <=
//          granted slot, evtValid <= 0, go to IDLE.
//  Timing:
//   - Latency: edge pulse at cycle N -> flag set at N+1 -> evtValid=1 at N+2
//     (when the FSM is IDLE).
//   - Throughput: at most one event per 2 cycles (evtValid is low for one
//     cycle between grants).
//  Fairness: a slot that stays asserted waits at most 2*NUM_CH-1 grants.
//  pending[c] = flag[2c] | flag[2c+1]; registered flags, no extra delay.
//  evtReady while evtValid=0 is ignored.
// TESTING
//  1 riseIn[2] pulse, evtReady=0 -> evtValid=1 two cycles later, evtChan=2,
//    evtRising=1. Outputs held 10 cycles. evtReady=1 -> evtValid=0 next
//    cycle, pending=0.
//  2 riseIn[0],[1],[3] in the same cycle, evtReady=1 -> grants in order ch0,
//    ch1, ch3, each evtRising=1, spaced 2 cycles apart.
//  3 riseIn[4] and fallIn[4] in the same cycle -> two events: (4,rise) then
//    (4,fall). No overflow.
//  4 Two riseIn[1] pulses 3 cycles apart, evtReady=0 -> overflow=1, exactly
//    one (1,rise) event delivered. overflowClr pulse -> overflow=0.
//  5 ch0 and ch4 re-pulse riseIn every 4 cycles, evtReady=1 -> grants
//    alternate ch0, ch4, ch0, ... No starvation.
//  6 enableMask[3]=0 and riseIn[3] pulse -> no event. Then reset mid-OFFER
//    -> evtValid/pending/overflow=0 without waiting for a clk edge.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
//   Collects one-clock rise/fall pulses from NUM_CH edge detectors into
//   pending flags and hands them one at a time to a single consumer through
//   a valid/ready handshake, in round-robin slot order.
//   While the consumer is busy, a pulse is still caught in its flag.
//
// Ports
//   clk          system clock, rising edge
//   resetN       asynchronous active-low reset
//   riseIn       rising-edge pulses, one bit per channel
//   fallIn       falling-edge pulses, one bit per channel
//   enableMask   1 = channel may post new events
//   evtReady     consumer accepts the offered event
//   evtValid     an event is offered on evtChan/evtRising
//   evtChan      channel index of the offered event
//   evtRising    1 = rising edge, 0 = falling edge
//   pending      per channel, OR of its rise and fall flags
//   overflow     sticky: an edge hit a flag that was already set
//   overflowClr  one-cycle pulse that clears overflow
//
// Slot numbering: slot 2c is the rise of channel c, slot 2c+1 its fall.
module edge_event_arbiter #(
  parameter int NUM_CH = 5,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [NUM_CH-1:0] riseIn,
  input  logic [NUM_CH-1:0] fallIn,
  input  logic [NUM_CH-1:0] enableMask,
  input  logic              evtReady,
  output logic              evtValid,
  output logic [IDX_W-1:0]  evtChan,
  output logic              evtRising,
  output logic [NUM_CH-1:0] pending,
  output logic              overflow,
  input  logic              overflowClr
);

  localparam int NUM_SLOT = 2 * NUM_CH;
  localparam int SLOT_W   = $clog2(NUM_SLOT);
  localparam logic [NUM_SLOT-1:0] SLOT_ONE = {{(NUM_SLOT-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_SLOT-1:0] flags_q, flags_d;
  logic [SLOT_W-1:0]   rr_q, rr_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                evt_valid_q, evt_valid_d;
  logic [IDX_W-1:0]    evt_chan_q, evt_chan_d;
  logic                evt_rising_q, evt_rising_d;
  logic                overflow_q, overflow_d;

  logic [NUM_SLOT-1:0] set_s;
  logic [NUM_SLOT-1:0] clr_s;
  logic                grant_s;
  logic                ovf_hit_s;
  logic                found_s;
  logic [SLOT_W-1:0]   next_slot_s;

  // Slot index base+ofs, wrapped into 0..NUM_SLOT-1 (ofs never exceeds NUM_SLOT).
  function automatic logic [SLOT_W-1:0] wrap_slot(input int base, input int ofs);
    int sum;
    sum = base + ofs;
    if (sum >= NUM_SLOT) begin
      sum = sum - NUM_SLOT;
    end else begin
      sum = sum;
    end
    return sum[SLOT_W-1:0];
  endfunction

  // Masked edge pulses mapped onto their slots.
  always_comb begin
    set_s = {NUM_SLOT{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      set_s[2*c]   = riseIn[c] & enableMask[c];
      set_s[2*c+1] = fallIn[c] & enableMask[c];
    end
  end

  // Flag update: a grant clears its slot, but a same-cycle set on that slot wins.
  always_comb begin
    grant_s    = (state_q == ST_OFFER) & evtReady;
    clr_s      = grant_s ? (SLOT_ONE << slot_q) : {NUM_SLOT{1'b0}};
    flags_d    = (flags_q & ~clr_s) | set_s;
    // Only a flag that survives this cycle can be overrun.
    ovf_hit_s  = |(set_s & flags_q & ~clr_s);
    overflow_d = ovf_hit_s ? 1'b1 : (overflowClr ? 1'b0 : overflow_q);
  end

  // Round-robin search: first set slot after rr_q with wrap. Walking from the
  // farthest candidate down to the nearest lets the nearest one win.
  always_comb begin
    found_s     = 1'b0;
    next_slot_s = {SLOT_W{1'b0}};
    for (int i = NUM_SLOT; i >= 1; i--) begin
      found_s     = found_s | flags_q[wrap_slot(int'(rr_q), i)];
      next_slot_s = flags_q[wrap_slot(int'(rr_q), i)] ? wrap_slot(int'(rr_q), i) : next_slot_s;
    end
  end

  // Handshake FSM next state and registered event outputs.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    slot_d       = slot_q;
    evt_valid_d  = evt_valid_q;
    evt_chan_d   = evt_chan_q;
    evt_rising_d = evt_rising_q;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          state_d      = ST_OFFER;
          slot_d       = next_slot_s;
          evt_valid_d  = 1'b1;
          evt_chan_d   = IDX_W'(next_slot_s[SLOT_W-1:1]);
          evt_rising_d = ~next_slot_s[0];
        end else begin
          evt_valid_d  = 1'b0;
        end
      end
      ST_OFFER: begin
        if (evtReady) begin
          state_d     = ST_IDLE;
          rr_d        = slot_q;
          evt_valid_d = 1'b0;
        end else begin
          evt_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        evt_valid_d = 1'b0;
      end
    endcase
  end

  // All state registers; the pointer resets to the last slot so the first
  // search after reset begins at slot 0.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= ST_IDLE;
      flags_q      <= {NUM_SLOT{1'b0}};
      rr_q         <= SLOT_W'(NUM_SLOT - 1);
      slot_q       <= {SLOT_W{1'b0}};
      evt_valid_q  <= 1'b0;
      evt_chan_q   <= {IDX_W{1'b0}};
      evt_rising_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      flags_q      <= flags_d;
      rr_q         <= rr_d;
      slot_q       <= slot_d;
      evt_valid_q  <= evt_valid_d;
      evt_chan_q   <= evt_chan_d;
      evt_rising_q <= evt_rising_d;
      overflow_q   <= overflow_d;
    end
  end

  // pending is a direct view of the registered flags.
  always_comb begin
    pending = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      pending[c] = flags_q[2*c] | flags_q[2*c+1];
    end
  end

  assign evtValid  = evt_valid_q;
  assign evtChan   = evt_chan_q;
  assign evtRising = evt_rising_q;
  assign overflow  = overflow_q;

endmodule
